// File: rtl/mul_hilo_unit_pkg.sv
// Shared encodings and defaults for the HI/LO multiply commit unit.
// Also used by mul_unsigned_fix, which the divider result path will share.
package mul_hilo_unit_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 31;

  // Encoding 3 is reserved and behaves as OP_MULT.
  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_MADD = 2'd1;
  localparam logic [1:0] OP_MSUB = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CORRECT = 2'd2,
    WRITE   = 2'd3
  } state_e;

endpackage

// File: rtl/mul_hilo_unit_fix.sv
// Converts a signed WIDTHxWIDTH product into the unsigned product when uns is set.
// This block is purely combinational.
module mul_unsigned_fix
  import mul_hilo_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [2*WIDTH-1:0] prod,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  input  logic                      uns,
  output logic signed [2*WIDTH-1:0] p
);

  logic [WIDTH-1:0] hi_adj;

  // An operand with its MSB set is worth 2^WIDTH more unsigned than signed.
  // So the fix only ever adds to the upper word.
  always_comb begin
    hi_adj = '0;
    if (a[WIDTH-1]) hi_adj = hi_adj + b;
    if (b[WIDTH-1]) hi_adj = hi_adj + a;
    p = prod;
    if (uns) p = prod + signed'({hi_adj, {WIDTH{1'b0}}});
  end

endmodule

// File: rtl/mul_hilo_unit.sv
// Takes the Booth multiplier product, applies unsigned correction and MADD/MSUB,
// and commits to HI/LO. Also handles MTHI/MTLO writes.
module mul_hilo_unit
  import mul_hilo_unit_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic                      req_unsigned,
  input  logic [WIDTH-1:0]          req_a,
  input  logic [WIDTH-1:0]          req_b,
  input  logic                      prod_valid,
  input  logic signed [2*WIDTH-1:0] prod,
  input  logic                      mt_hi_we,
  input  logic                      mt_lo_we,
  input  logic [WIDTH-1:0]          mt_wdata,
  output logic [WIDTH-1:0]          hi,
  output logic [WIDTH-1:0]          lo,
  output logic                      busy,
  output logic                      done,
  output logic                      err_timeout,
  output logic                      wr_conflict
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             take_prod;
  logic             expire;
  logic             mt_any;

  logic [1:0]                op_p0;
  logic                      uns_p0;
  logic signed [WIDTH-1:0]   a_p0;
  logic signed [WIDTH-1:0]   b_p0;
  logic signed [2*WIDTH-1:0] prod_p1;
  logic signed [2*WIDTH-1:0] fix_p1;
  logic signed [2*WIDTH-1:0] p_p2;

  // Arithmetic wraps modulo 2^(2*WIDTH); there is no saturation.
  function automatic logic [2*WIDTH-1:0] acc_wrap(input logic [1:0] op,
                                                  input logic [2*WIDTH-1:0] base,
                                                  input logic [2*WIDTH-1:0] p);
    case (op)
      OP_MADD: return base + p;
      OP_MSUB: return base - p;
      default: return p;
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_ready && req_valid;
  assign mt_any    = mt_hi_we || mt_lo_we;
  assign cnt_inc   = cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_prod = 1'b0;
    expire    = 1'b0;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT: begin
        if (prod_valid) begin
          state_nxt = CORRECT;
          take_prod = 1'b1;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_nxt = IDLE;
          expire    = 1'b1;
        end
      end
      CORRECT: state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      if (accept)              cnt <= '0;
      else if (state == WAIT)  cnt <= cnt_inc;
      done        <= (state == WRITE);
      err_timeout <= expire;
      wr_conflict <= busy && mt_any;
    end
  end

  // MT writes land only in IDLE, so any accumulate base already includes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == WRITE) begin
      {hi, lo} <= acc_wrap(op_p0, {hi, lo}, p_p2);
    end else if (state == IDLE) begin
      if (mt_hi_we) hi <= mt_wdata;
      if (mt_lo_we) lo <= mt_wdata;
    end
  end

  // p0: request operands
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= req_op;
      uns_p0 <= req_unsigned;
      a_p0   <= req_a;
      b_p0   <= req_b;
    end
  end

  // p1: raw product from the multiplier
  always_ff @(posedge clk) begin
    if (take_prod) prod_p1 <= prod;
  end

  mul_unsigned_fix #(.WIDTH(WIDTH)) u_fix (
    .prod (prod_p1),
    .a    (a_p0),
    .b    (b_p0),
    .uns  (uns_p0),
    .p    (fix_p1)
  );

  // p2: corrected product
  always_ff @(posedge clk) begin
    if (state == CORRECT) p_p2 <= fix_p1;
  end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit: a scoreboard queue holds expected HI/LO per request,
// and a reference model tracks HI/LO across MT writes, timeouts and reset.
module tb_mul_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_unsigned;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        prod_valid;
  logic [63:0] prod;
  logic        mt_hi_we;
  logic        mt_lo_we;
  logic [31:0] mt_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        wr_conflict;

  always #5 clk = ~clk;

  mul_hilo_unit #(.WIDTH(32), .TIMEOUT(31)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_unsigned (req_unsigned),
    .req_a        (req_a),
    .req_b        (req_b),
    .prod_valid   (prod_valid),
    .prod         (prod),
    .mt_hi_we     (mt_hi_we),
    .mt_lo_we     (mt_lo_we),
    .mt_wdata     (mt_wdata),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout),
    .wr_conflict  (wr_conflict)
  );

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic uns,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_unsigned = uns; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Drives the multiplier product, queues the expected result, waits for done.
  task automatic complete(input string tag, input logic [1:0] op, input logic uns,
                          input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] sp, full, res, got;
    int          n;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sp   = 64'(sa * sb);
    full = uns ? ({32'b0, a} * {32'b0, b}) : sp;
    if (op == 2'd1)      res = {m_hi, m_lo} + full;
    else if (op == 2'd2) res = {m_hi, m_lo} - full;
    else                 res = full;
    @(negedge clk);
    prod = sp; prod_valid = 1'b1;
    exp_q.push_back(res);
    @(posedge clk); #1;
    prod_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd2);
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      chk({tag, "_hilo"}, {hi, lo}, got);
      m_hi = got[63:32];
      m_lo = got[31:0];
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    mt_hi_we = hw; mt_lo_we = lw; mt_wdata = d;
    @(posedge clk); #1;
    mt_hi_we = 1'b0; mt_lo_we = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
  endtask

  // A stray product strobe must produce no commit and no done.
  task automatic stray_prod(input string tag);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    prod = 64'h0123_4567_89AB_CDEF; prod_valid = 1'b1;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    seen = seen | done;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | done;
    end
    chk({tag, "_no_done"}, 64'(seen), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_unsigned = 1'b0;
    req_a = '0; req_b = '0; prod_valid = 1'b0; prod = '0;
    mt_hi_we = 1'b0; mt_lo_we = 1'b0; mt_wdata = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_pulses", {61'd0, done, err_timeout, wr_conflict}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(2'd0, 1'b0, 32'hFFFF_FFFD, 32'd5);
    chk("smult_busy", 64'(busy), 64'd1);
    chk("smult_ready", 64'(req_ready), 64'd0);
    complete("smult", 2'd0, 1'b0, 32'hFFFF_FFFD, 32'd5);
    chk("smult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    issue(2'd0, 1'b1, 32'hFFFF_FFFF, 32'd2);
    complete("umult", 2'd0, 1'b1, 32'hFFFF_FFFF, 32'd2);
    chk("umult_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    mt_write(1'b1, 1'b0, 32'd1);
    mt_write(1'b0, 1'b1, 32'd0);
    chk("mt_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    issue(2'd1, 1'b0, 32'd2, 32'd2);
    complete("madd", 2'd1, 1'b0, 32'd2, 32'd2);
    chk("madd_const", {hi, lo}, 64'h0000_0001_0000_0004);
    issue(2'd2, 1'b0, 32'd3, 32'h5555_5557);
    complete("msub", 2'd2, 1'b0, 32'd3, 32'h5555_5557);
    chk("msub_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    issue(2'd3, 1'b1, 32'h8000_0000, 32'h8000_0000);
    complete("rsvd_umult", 2'd3, 1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("rsvd_const", {hi, lo}, 64'h4000_0000_0000_0000);
    issue(2'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    complete("umadd", 2'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    issue(2'd0, 1'b0, 32'd5, 32'd5);
    n = 0;
    while (err_timeout !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'd31);
    chk("tmo_ready", 64'(req_ready), 64'd1);
    chk("tmo_hilo", {hi, lo}, {m_hi, m_lo});
    @(posedge clk); #1;
    chk("tmo_pulse", 64'(err_timeout), 64'd0);
    stray_prod("tmo_stray");

    issue(2'd0, 1'b0, 32'd7, 32'd6);
    @(negedge clk);
    mt_lo_we = 1'b1; mt_wdata = 32'h1234;
    @(posedge clk); #1;
    mt_lo_we = 1'b0;
    chk("conflict_pulse", 64'(wr_conflict), 64'd1);
    chk("conflict_lo", 64'(lo), 64'(m_lo));
    @(posedge clk); #1;
    chk("conflict_clear", 64'(wr_conflict), 64'd0);
    complete("conflict_mul", 2'd0, 1'b0, 32'd7, 32'd6);

    @(negedge clk);
    mt_hi_we = 1'b1; mt_wdata = 32'h0000_DEAD;
    req_valid = 1'b1; req_op = 2'd0; req_unsigned = 1'b0;
    req_a = 32'h0001_0000; req_b = 32'h0003_0000;
    @(posedge clk); #1;
    mt_hi_we = 1'b0; req_valid = 1'b0;
    m_hi = 32'h0000_DEAD;
    chk("mtreq_hi", 64'(hi), 64'h0000_DEAD);
    chk("mtreq_busy", 64'(busy), 64'd1);
    complete("mtreq", 2'd0, 1'b0, 32'h0001_0000, 32'h0003_0000);
    chk("mtreq_final_hi", 64'(hi), 64'd3);

    mt_write(1'b1, 1'b0, 32'h0000_AAAA);
    chk("pre_rst_hi", 64'(hi), 64'h0000_AAAA);
    issue(2'd0, 1'b0, 32'd4, 32'd4);
    @(negedge clk);
    prod = 64'd16; prod_valid = 1'b1;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    stray_prod("post_rst");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
